issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of instruction-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter SEQ_W, default 32: width of the per-entry age sequence number.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enq_valid, input, 1: the decode stage offers an instruction.
REQ-006 SHALL have port enq_ready, output, 1: the scheduler can accept an instruction this cycle.
REQ-007 SHALL have port enq_alu_ctl, input, 5: AluCtl opcode of the offered instruction.
REQ-008 SHALL have ports enq_rs_phys, enq_rt_phys and enq_rw_phys, input, 6 each: MipsReg physical source and destination registers.
REQ-009 SHALL have ports enq_uses_rs, enq_uses_rt and enq_uses_rw, input, 1 each: operand-usage flags.
REQ-010 SHALL have ports wb_valid, input, 1, and wb_phys, input, 6: the writeback broadcast marking a physical register as produced.
REQ-011 SHALL have ports iss_valid, output, 1, and iss_ready, input, 1: the issue handshake to execute.
REQ-012 SHALL have ports iss_alu_ctl (5), iss_rs_phys, iss_rt_phys and iss_rw_phys (6 each), and iss_uses_rw (1), all outputs: the payload of the selected entry.
REQ-013 SHALL have port flush, input, 1: a branch mispredict that discards all queued state.
REQ-014 SHALL have ports occupancy, output, $clog2(DEPTH)+1: the number of valid entries; empty and full, output, 1 each.

Function
REQ-015 enq_ready SHALL equal (occupancy < DEPTH), taken from registered state only; an issue in the same cycle does not free a slot for enqueue.
REQ-016 Enqueue (enq_valid && enq_ready && !flush) SHALL write the lowest-index free entry, stamp it with the current seq counter, then increment seq modulo 2^SEQ_W.
REQ-017 Per-source ready at enqueue SHALL be set if the source is unused, or phys==0, or the scoreboard shows the register not busy, or wb_valid && wb_phys matches in the same cycle.
REQ-018 The scoreboard (64 busy bits) SHALL set busy[rw] on enqueue when uses_rw && rw!=0, and clear busy[wb_phys] on wb_valid.
REQ-019 If set and clear hit the same register in one cycle, set SHALL win.
REQ-020 Wakeup: a wb_valid to register P SHALL set the ready bit of every valid entry source equal to P, registered at the clock edge.
REQ-021 An entry SHALL be eligible when it is valid and both source ready bits are set.
REQ-022 iss_valid SHALL be high iff any entry is eligible and flush is low.
REQ-023 The payload SHALL come from the oldest eligible entry: A is older than B iff (seqA - seqB) mod 2^SEQ_W has its MSB set; equal age cannot occur.
REQ-024 Wrap-around of seq SHALL NOT change selection order, because at most DEPTH entries are outstanding.
REQ-025 On iss_valid && iss_ready the selected entry SHALL be invalidated at the clock edge; with iss_ready low the same entry SHALL stay presented unless an older entry becomes eligible.
REQ-026 Enqueue and issue in the same cycle SHALL leave occupancy unchanged.
REQ-027 Baseline latency: an instruction enqueued in cycle N with all sources ready SHALL be issuable in N+1; an entry woken by wb in cycle N SHALL be issuable in N+1.
REQ-028 flush SHALL, at the edge, invalidate all entries and clear all busy bits, and SHALL take priority over enqueue and issue in the same cycle; seq is not reset.
REQ-029 occupancy, empty and full SHALL reflect registered entry-valid state.

Reset
REQ-030 On rst at the clock edge: all entries invalid, all busy bits clear, seq=0, occupancy=0, empty=1, full=0, enq_ready=1, iss_valid=0.
REQ-031 A reset asserted mid-operation SHALL discard all entries with no issue in that cycle, taking priority over flush, enqueue and wb.

Configuration
REQ-032 With macro ISSUE_WAKEUP_BYPASS_EN defined, eligibility SHALL also treat a source as ready when wb_valid && wb_phys matches in the current cycle, so a woken entry issues in cycle N instead of N+1; without the macro, wakeup is registered only (REQ-027).

Verification
REQ-033 Reset, then enqueue add (rs=3, rt=4, rw=5) with no busy registers -> iss_valid=1 next cycle with iss_rw_phys=5; occupancy 1 -> 0 after the handshake.
REQ-034 Enqueue I1 with rw=7, then I2 with rs=7 -> I2 is not eligible; wb_valid with wb_phys=7 in cycle N -> I2 issues in N+1, or in N with ISSUE_WAKEUP_BYPASS_EN.
REQ-035 Fill 8 entries with iss_ready=0 -> full=1 and enq_ready=0; a 9th enq_valid is ignored; one issue -> enq_ready=1 the next cycle.
REQ-036 Preload seq=0xFFFFFFFE, enqueue 3 ready instructions (seq wraps) -> they issue in enqueue order.
REQ-037 Raise flush with enq_valid=1, an eligible entry and iss_ready=1 -> iss_valid=0 in that cycle, occupancy=0 and all busy bits clear after the edge.
REQ-038 Raise rst while occupancy=5 and wb_valid=1 -> next cycle occupancy=0, empty=1, iss_valid=0.

Source files
------------

// File: rtl/issue_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : issue_scheduler
// Brief    : Age-ordered out-of-order issue queue with a 64-entry register
//            busy scoreboard. Optional macro ISSUE_WAKEUP_BYPASS_EN lets a
//            same-cycle writeback make an entry eligible immediately.
// Revision : 1.0 - initial release
// =============================================================================
module issue_scheduler #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [4:0]             enq_alu_ctl,
  input  logic [5:0]             enq_rs_phys,
  input  logic [5:0]             enq_rt_phys,
  input  logic [5:0]             enq_rw_phys,
  input  logic                   enq_uses_rs,
  input  logic                   enq_uses_rt,
  input  logic                   enq_uses_rw,
  input  logic                   wb_valid,
  input  logic [5:0]             wb_phys,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [4:0]             iss_alu_ctl,
  output logic [5:0]             iss_rs_phys,
  output logic [5:0]             iss_rt_phys,
  output logic [5:0]             iss_rw_phys,
  output logic                   iss_uses_rw,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   empty,
  output logic                   full
);

  localparam int                 c_IDX_W     = $clog2(DEPTH);
  localparam logic [c_IDX_W:0]   c_DEPTH_CNT = (c_IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [DEPTH-1:0]   rs_rdy_q, rs_rdy_d;
  logic [DEPTH-1:0]   rt_rdy_q, rt_rdy_d;
  logic [63:0]        busy_q, busy_d;
  logic [SEQ_W-1:0]   seq_ctr_q, seq_ctr_d;

  logic [SEQ_W-1:0]   seq_q [DEPTH];
  logic [4:0]         alu_q [DEPTH];
  logic [5:0]         rs_q  [DEPTH];
  logic [5:0]         rt_q  [DEPTH];
  logic [5:0]         rw_q  [DEPTH];
  logic [DEPTH-1:0]   urw_q;

  logic [DEPTH-1:0]   rs_ok, rt_ok, elig;
  logic [c_IDX_W-1:0] free_idx, sel_idx;
  logic [c_IDX_W:0]   occ;
  logic               sel_found, do_enq, do_iss, enq_rs_rdy, enq_rt_rdy;

  // Modular age compare: a is older than b when (a - b) wraps negative.
  function automatic logic older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return diff[SEQ_W-1];
  endfunction

  always_comb begin
    occ      = '0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      occ = occ + (c_IDX_W+1)'(vld_q[i]);
      if (!vld_q[i]) free_idx = c_IDX_W'(i);
    end
  end

  assign occupancy = occ;
  assign empty     = (occ == '0);
  assign full      = (occ == c_DEPTH_CNT);
  assign enq_ready = ~full;

  always_comb begin
    rs_ok = '0;
    rt_ok = '0;
    elig  = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ISSUE_WAKEUP_BYPASS_EN
      rs_ok[i] = rs_rdy_q[i] | (wb_valid & (wb_phys == rs_q[i]));
      rt_ok[i] = rt_rdy_q[i] | (wb_valid & (wb_phys == rt_q[i]));
`else
      rs_ok[i] = rs_rdy_q[i];
      rt_ok[i] = rt_rdy_q[i];
`endif
      elig[i] = vld_q[i] & rs_ok[i] & rt_ok[i];
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!sel_found || older(seq_q[i], seq_q[sel_idx]))) begin
        sel_idx   = c_IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign iss_valid   = sel_found & ~flush & ~rst;
  assign iss_alu_ctl = alu_q[sel_idx];
  assign iss_rs_phys = rs_q[sel_idx];
  assign iss_rt_phys = rt_q[sel_idx];
  assign iss_rw_phys = rw_q[sel_idx];
  assign iss_uses_rw = urw_q[sel_idx];

  assign do_iss = iss_valid & iss_ready;
  assign do_enq = enq_valid & enq_ready & ~flush;

  assign enq_rs_rdy = ~enq_uses_rs | (enq_rs_phys == 6'd0) | ~busy_q[enq_rs_phys]
                    | (wb_valid & (wb_phys == enq_rs_phys));
  assign enq_rt_rdy = ~enq_uses_rt | (enq_rt_phys == 6'd0) | ~busy_q[enq_rt_phys]
                    | (wb_valid & (wb_phys == enq_rt_phys));

  always_comb begin
    vld_d     = vld_q;
    rs_rdy_d  = rs_rdy_q;
    rt_rdy_d  = rt_rdy_q;
    busy_d    = busy_q;
    seq_ctr_d = seq_ctr_q;
    if (flush) begin
      vld_d  = '0;
      busy_d = '0;
    end else begin
      if (wb_valid) begin
        busy_d[wb_phys] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (rs_q[i] == wb_phys) rs_rdy_d[i] = 1'b1;
          if (rt_q[i] == wb_phys) rt_rdy_d[i] = 1'b1;
        end
      end
      if (do_iss) vld_d[sel_idx] = 1'b0;
      // Enqueue is applied after the writeback clear so a same-register set wins.
      if (do_enq) begin
        vld_d[free_idx]    = 1'b1;
        rs_rdy_d[free_idx] = enq_rs_rdy;
        rt_rdy_d[free_idx] = enq_rt_rdy;
        seq_ctr_d          = seq_ctr_q + SEQ_W'(1);
        if (enq_uses_rw && (enq_rw_phys != 6'd0)) busy_d[enq_rw_phys] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      rs_rdy_q  <= '0;
      rt_rdy_q  <= '0;
      busy_q    <= '0;
      seq_ctr_q <= '0;
    end else begin
      vld_q     <= vld_d;
      rs_rdy_q  <= rs_rdy_d;
      rt_rdy_q  <= rt_rdy_d;
      busy_q    <= busy_d;
      seq_ctr_q <= seq_ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      seq_q[free_idx] <= seq_ctr_q;
      alu_q[free_idx] <= enq_alu_ctl;
      rs_q[free_idx]  <= enq_rs_phys;
      rt_q[free_idx]  <= enq_rt_phys;
      rw_q[free_idx]  <= enq_rw_phys;
      urw_q[free_idx] <= enq_uses_rw;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_issue_scheduler
// Brief    : Scoreboard bench for issue_scheduler; a narrow sequence counter
//            makes the age-counter wrap reachable in a short run.
// Revision : 1.0 - initial release
// =============================================================================
module tb_issue_scheduler;
  localparam int DEPTH = 8;
  localparam int SEQ_W = 4;
`ifdef ISSUE_WAKEUP_BYPASS_EN
  localparam logic c_BYP = 1'b1;
`else
  localparam logic c_BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enq_valid = 1'b0, enq_ready;
  logic [4:0] enq_alu_ctl = '0;
  logic [5:0] enq_rs_phys = '0, enq_rt_phys = '0, enq_rw_phys = '0;
  logic       enq_uses_rs = 1'b0, enq_uses_rt = 1'b0, enq_uses_rw = 1'b0;
  logic       wb_valid = 1'b0;
  logic [5:0] wb_phys = '0;
  logic       iss_valid, iss_ready = 1'b0, iss_uses_rw;
  logic [4:0] iss_alu_ctl;
  logic [5:0] iss_rs_phys, iss_rt_phys, iss_rw_phys;
  logic       flush = 1'b0;
  logic [3:0] occupancy;
  logic       empty, full;

  logic [23:0] got, expv;
  logic [23:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, n_enq = 0;

  assign got = {iss_alu_ctl, iss_rs_phys, iss_rt_phys, iss_rw_phys, iss_uses_rw};

  always #5 clk = ~clk;

  issue_scheduler #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_alu_ctl(enq_alu_ctl),
    .enq_rs_phys(enq_rs_phys), .enq_rt_phys(enq_rt_phys), .enq_rw_phys(enq_rw_phys),
    .enq_uses_rs(enq_uses_rs), .enq_uses_rt(enq_uses_rt), .enq_uses_rw(enq_uses_rw),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_alu_ctl(iss_alu_ctl),
    .iss_rs_phys(iss_rs_phys), .iss_rt_phys(iss_rt_phys), .iss_rw_phys(iss_rw_phys),
    .iss_uses_rw(iss_uses_rw), .flush(flush),
    .occupancy(occupancy), .empty(empty), .full(full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0; wb_valid = 1'b0; wb_phys = '0; iss_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic offer(input logic [4:0] alu, input logic [5:0] rs, input logic [5:0] rt,
                       input logic [5:0] rw, input logic urs, input logic urt,
                       input logic urw, input bit accept);
    enq_valid = 1'b1; enq_alu_ctl = alu; enq_rs_phys = rs; enq_rt_phys = rt; enq_rw_phys = rw;
    enq_uses_rs = urs; enq_uses_rt = urt; enq_uses_rw = urw;
    if (accept) begin
      exp_q.push_back({alu, rs, rt, rw, urw});
      n_enq++;
    end
  endtask

  task automatic clean();
    idle(); flush = 1'b1; tick(); flush = 1'b0; exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    tick();
  endtask

  task automatic test_basic();
    offer(5'd1, 6'd3, 6'd4, 6'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL basic_same_cycle: got %b want 0", iss_valid); end
    tick();
    enq_valid = 1'b0; iss_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd1) begin n_bad++; $display("FAIL basic_occ1: got %0d want 1", occupancy); end
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL basic_issue: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    iss_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL basic_occ0: got %0d/%b want 0/1", occupancy, empty); end
    tick();
  endtask

  task automatic test_wakeup();
    clean();
    offer(5'd2, 6'd0, 6'd0, 6'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    offer(5'd3, 6'd7, 6'd0, 6'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (iss_valid !== 1'b1 || got !== exp_q[0]) begin n_bad++; $display("FAIL wake_i1_present: got v=%b %h want v=1 %h", iss_valid, got, exp_q[0]); end
    tick();
    enq_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (iss_rw_phys !== 6'd7) begin n_bad++; $display("FAIL wake_i1_hold: got %0d want 7", iss_rw_phys); end
    tick();
    iss_ready = 1'b1;
    @(negedge clk);
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL wake_i1_issue: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    iss_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL wake_i2_blocked: got %b want 0", iss_valid); end
    tick();
    wb_valid = 1'b1; wb_phys = 6'd7;
    @(negedge clk);
    n_cmp++; if (iss_valid !== c_BYP) begin n_bad++; $display("FAIL wake_wb_cycle: got %b want %b", iss_valid, c_BYP); end
    tick();
    wb_valid = 1'b0; iss_ready = 1'b1;
    @(negedge clk);
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL wake_i2_issue: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_set_wins();
    clean();
    offer(5'd10, 6'd0, 6'd0, 6'd20, 1'b0, 1'b0, 1'b1, 1'b1);
    wb_valid = 1'b1; wb_phys = 6'd20;
    tick();
    wb_valid = 1'b0; iss_ready = 1'b1;
    offer(5'd11, 6'd20, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL setwin_a_issue: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    enq_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL setwin_b_blocked: got %b want 0", iss_valid); end
    tick();
    iss_ready = 1'b0; wb_valid = 1'b1; wb_phys = 6'd20;
    offer(5'd12, 6'd20, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (iss_valid !== c_BYP) begin n_bad++; $display("FAIL setwin_wb_cycle: got %b want %b", iss_valid, c_BYP); end
    tick();
    idle(); iss_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      expv = exp_q.pop_front();
      n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL setwin_drain%0d: got v=%b %h want v=1 %h", k, iss_valid, got, expv); end
      tick();
    end
    iss_ready = 1'b0;
  endtask

  task automatic test_full();
    clean();
    for (int i = 0; i < DEPTH; i++) begin
      offer(5'(i), 6'(i), 6'(i+1), 6'(10+i), 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill%0d: got enq_ready=%b want 1", i, enq_ready); end
      tick();
    end
    offer(5'd31, 6'd1, 6'd2, 6'd40, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (full !== 1'b1 || enq_ready !== 1'b0 || occupancy !== 4'd8) begin n_bad++; $display("FAIL full_flags: got full=%b rdy=%b occ=%0d want 1/0/8", full, enq_ready, occupancy); end
    tick();
    enq_valid = 1'b0; iss_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd8) begin n_bad++; $display("FAIL full_ninth_ignored: got %0d want 8", occupancy); end
    n_cmp++; if (enq_ready !== 1'b0) begin n_bad++; $display("FAIL full_no_same_cycle_free: got %b want 0", enq_ready); end
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL full_first_issue: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    offer(5'd9, 6'd0, 6'd0, 6'd30, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after_issue: got %b want 1", enq_ready); end
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL full_enq_iss_issue: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd7) begin n_bad++; $display("FAIL full_enq_iss_occ: got %0d want 7", occupancy); end
    tick();
    iss_ready = 1'b1;
    for (int k = 0; k < 4*DEPTH && exp_q.size() > 0; k++) begin
      @(negedge clk);
      expv = exp_q.pop_front();
      n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL full_drain%0d: got v=%b %h want v=1 %h", k, iss_valid, got, expv); end
      tick();
    end
    iss_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL full_drained_empty: got %b want 1", empty); end
    tick();
  endtask

  task automatic test_wrap();
    clean();
    for (int k = 0; k < 32 && (n_enq % (1 << SEQ_W)) != (1 << SEQ_W) - 2; k++) begin
      offer(5'd4, 6'd0, 6'd0, 6'(50+k), 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      enq_valid = 1'b0; iss_ready = 1'b1;
      @(negedge clk);
      expv = exp_q.pop_front();
      n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL wrap_filler%0d: got v=%b %h want v=1 %h", k, iss_valid, got, expv); end
      tick();
      iss_ready = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      offer(5'(20+j), 6'(j), 6'(j), 6'(60+j), 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    idle(); iss_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      expv = exp_q.pop_front();
      n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL wrap_order%0d: got v=%b %h want v=1 %h", j, iss_valid, got, expv); end
      tick();
    end
    iss_ready = 1'b0;
  endtask

  task automatic test_flush();
    clean();
    offer(5'd5, 6'd0, 6'd0, 6'd12, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    offer(5'd6, 6'd0, 6'd0, 6'd13, 1'b0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1; iss_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL flush_iss_valid: got %b want 0", iss_valid); end
    tick();
    idle(); exp_q.delete();
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL flush_occ: got %0d/%b want 0/1", occupancy, empty); end
    tick();
    offer(5'd7, 6'd12, 6'd13, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    enq_valid = 1'b0; iss_ready = 1'b1;
    @(negedge clk);
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL flush_busy_cleared: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    clean();
    for (int j = 0; j < 5; j++) begin
      offer(5'(j), 6'd0, 6'd0, 6'(j+1), 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    offer(5'd8, 6'd0, 6'd0, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; wb_valid = 1'b1; wb_phys = 6'd2; iss_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd5) begin n_bad++; $display("FAIL rstmid_pre_occ: got %0d want 5", occupancy); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_issue: got %b want 0", iss_valid); end
    tick();
    rst = 1'b0; idle(); exp_q.delete();
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_occ: got %0d/%b want 0/1", occupancy, empty); end
    n_cmp++; if (iss_valid !== 1'b0 || enq_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_flags: got v=%b rdy=%b want 0/1", iss_valid, enq_ready); end
    tick();
    offer(5'd13, 6'd3, 6'd4, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    enq_valid = 1'b0; iss_ready = 1'b1;
    @(negedge clk);
    expv = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1 || got !== expv) begin n_bad++; $display("FAIL rstmid_busy_cleared: got v=%b %h want v=1 %h", iss_valid, got, expv); end
    tick();
    iss_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_set_wins();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want normal completion");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
